uart_rx_7seg: RTL and testbench
===============================

// Module: uart_rx_7seg
// PURPOSE
//  UART receiver (8N1, LSB first) decoding incoming ASCII hex digits onto a multiplexed
//  7-segment display. Receiving end of the pb_uart_7seg serial link: sits behind uart_rx
//  and drives leds_o/sels_o directly. Also exposes raw bytes for loopback checking.
// PARAMETERS
//  CLK_HZ    50_000_000  input clock frequency
//  BAUD      115200      line rate; BIT_CNT = CLK_HZ/BAUD (integer divide, 434 at defaults)
//  DIGITS    4           number of display digits (2..8)
//  SCAN_DIV  50_000      clocks per digit dwell (1 ms at defaults)
// PORTS
//  clk_50m      in   1       system clock, all logic on rising edge
//  sw_rst_n     in   1       asynchronous active-low reset
//  uart_rx      in   1       serial input, idle high, asynchronous to clk_50m
//  rx_data_o    out  8       last received byte, valid when rx_valid_o=1
//  rx_valid_o   out  1       one-cycle pulse per good frame
//  frame_err_o  out  1       one-cycle pulse when stop bit sampled low
//  leds_o       out  8       segments {dp,g,f,e,d,c,b,a}, active-low
//  sels_o       out  DIGITS  digit enables, active-low one-hot
// BEHAVIOUR
//  Reset: rx_data_o=0, rx_valid_o=0, frame_err_o=0, leds_o=8'hFF, sels_o=all 1,
//   FSM=IDLE, digit buffer all 0, scan index 0, counters 0. All outputs registered.
//  Input: uart_rx through 2-FF synchronizer (reset value 1); FSM sees sync'd rx_s.
//  RX FSM:
//   IDLE  : rx_s=0 -> START, bit counter cleared.
//   START : after BIT_CNT/2 cycles resample; rx_s=1 -> IDLE (glitch reject), else DATA.
//   DATA  : sample every BIT_CNT cycles at bit centre, shift in LSB first; after 8th -> STOP.
//   STOP  : sample after BIT_CNT cycles. 1 -> rx_data_o<=byte, rx_valid_o=1 next cycle, IDLE.
//           0 -> frame_err_o=1 one cycle, byte discarded, -> BREAK.
//   BREAK : wait for rx_s=1, then IDLE (no false restart during line break).
//  rx_data_o holds value until next good frame.
//  Byte decode (only on rx_valid):
//   '0'-'9' (30-39), 'A'-'F' (41-46), 'a'-'f' (61-66): buffer shifts one digit toward MSD,
//     new nibble enters digit 0; MSD value dropped.
//   8'h0C (form feed): all digits cleared to 0.
//   any other byte: buffer unchanged.
//  Scan: counter counts 0..SCAN_DIV-1; at wrap, index advances 0..DIGITS-1 then wraps to 0,
//   and sels_o/leds_o are reloaded together for the new index (no ghosting: both change same
//   cycle). First display update occurs on first wrap after reset (SCAN_DIV cycles), index 0.
//   sels_o = ~(1<<index). dp always off (bit7=1).
//  Seg codes: 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E.
//  Simultaneous buffer update and scan wrap: wrap uses the pre-update buffer; new value
//   appears at next wrap.
//  Reset mid-frame: FSM returns to IDLE immediately, partial byte lost, no pulse emitted.
// TESTING
//  1 Assert sw_rst_n=0 then release -> all outputs at reset values; first wrap at 50_000 clocks
//    gives sels_o=4'b1110, leds_o=8'hC0.
//  2 Send 0x35 at 115200 -> rx_valid_o exactly one cycle, rx_data_o=8'h35; digit 0 shows 8'h92.
//  3 Send "1","2","3","4" -> scan sequence sels_o 1110/1101/1011/0111 with leds_o 99/B0/A4/F9;
//    then send 0x0C -> all digits C0.
//  4 Frame 0x41 with stop bit held low 2 bit times -> frame_err_o one pulse, no rx_valid_o,
//    buffer unchanged; following good 0x46 received (digit 0 = 8E).
//  5 200-cycle low glitch on uart_rx -> no rx_valid_o/frame_err_o; FSM back in IDLE.
//  6 Reset asserted during bit 4 of a frame -> no pulse; next frame 0x39 received, digit0=90.

Source files
------------

// File: rtl/uart_rx_7seg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_7seg
// Description : 8N1 UART receiver that turns ASCII hex digits into a shifting
//               multiplexed 7-segment display; also exposes raw received bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_7seg #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50_000
) (
    input  logic              clk_50m,
    input  logic              sw_rst_n,
    input  logic              uart_rx,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic [7:0]        leds_o,
    output logic [DIGITS-1:0] sels_o
);

    localparam int c_BIT_CNT = CLK_HZ / BAUD;
    localparam int c_CW      = (c_BIT_CNT > 2) ? $clog2(c_BIT_CNT) : 1;
    localparam int c_SW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW      = $clog2(DIGITS);
    localparam int c_BW      = DIGITS * 4;

    localparam logic [c_CW-1:0]   c_BIT_LAST  = c_CW'(c_BIT_CNT - 1);
    localparam logic [c_CW-1:0]   c_HALF_LAST = c_CW'(c_BIT_CNT / 2 - 1);
    localparam logic [c_SW-1:0]   c_SCAN_LAST = c_SW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0]   c_IDX_LAST  = c_IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_SEL_ONE   = DIGITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    rx_state_t         state_q, state_d;
    logic [1:0]        sync_q;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic [c_BW-1:0]   buf_q, buf_d;
    logic [c_SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [c_IW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] sels_q, sels_d;
    logic [7:0]        leds_q, leds_d;

    logic       w_rx_s;
    logic       w_hex_ok;
    logic [3:0] w_nib;
    logic [3:0] w_cur_nib;

    assign w_rx_s = sync_q[1];

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Receive FSM: start bit is confirmed at its centre, then every bit is sampled one bit time later
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {w_rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d = '0;
                    if (w_rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hex_ok = 1'b0;
        w_nib    = data_q[3:0];
        if (data_q inside {[8'h30:8'h39]}) begin
            w_hex_ok = 1'b1;
        end else if (data_q inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
            w_hex_ok = 1'b1;
            w_nib    = data_q[3:0] + 4'd9;
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (valid_q) begin
            if (w_hex_ok) begin
                buf_d = {buf_q[c_BW-5:0], w_nib};
            end else if (data_q == 8'h0C) begin
                buf_d = '0;
            end
        end
    end

    always_comb begin
        w_cur_nib = buf_q[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_IW'(i)) begin
                w_cur_nib = buf_q[i*4 +: 4];
            end
        end
    end

    // Select and segments reload on the same edge so no digit ever shows a neighbour's pattern
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        sels_d     = sels_q;
        leds_d     = leds_q;
        if (scan_cnt_q == c_SCAN_LAST) begin
            scan_cnt_d = '0;
            sels_d     = ~(c_SEL_ONE << idx_q);
            leds_d     = seg7(w_cur_nib);
            idx_d      = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            buf_q      <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sels_q     <= '1;
            leds_q     <= 8'hFF;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            buf_q      <= buf_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sels_q     <= sels_d;
            leds_q     <= leds_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign leds_o      = leds_q;
    assign sels_o      = sels_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_7seg
// Description : Randomised scoreboard bench for uart_rx_7seg with a digit-list
//               reference model of the display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_7seg;

    localparam int CLK_HZ   = 1_843_200;
    localparam int BAUD     = 115_200;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 64;
    localparam int BIT_T    = CLK_HZ / BAUD;

    logic              clk_50m  = 1'b0;
    logic              sw_rst_n = 1'b0;
    logic              uart_rx  = 1'b1;
    logic [7:0]        rx_data_o;
    logic              rx_valid_o;
    logic              frame_err_o;
    logic [7:0]        leds_o;
    logic [DIGITS-1:0] sels_o;

    uart_rx_7seg #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk_50m    (clk_50m),
        .sw_rst_n   (sw_rst_n),
        .uart_rx    (uart_rx),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .frame_err_o(frame_err_o),
        .leds_o     (leds_o),
        .sels_o     (sels_o)
    );

    always #5 clk_50m = ~clk_50m;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    int          exp_err = 0;
    logic [7:0]  mon_exp;
    int          model_dig[DIGITS];
    logic [7:0]  seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Display model: a list of digit values, newest at position 0
    function automatic void model_byte(input logic [7:0] b);
        int v;
        v = -1;
        if (b >= 8'd48 && b <= 8'd57)       v = b - 48;
        else if (b >= 8'd65 && b <= 8'd70)  v = b - 55;
        else if (b >= 8'd97 && b <= 8'd102) v = b - 87;
        if (v >= 0) begin
            for (int i = DIGITS - 1; i > 0; i--) model_dig[i] = model_dig[i-1];
            model_dig[0] = v;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < DIGITS; i++) model_dig[i] = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DIGITS; i++) model_dig[i] = 0;
    endfunction

    always @(negedge clk_50m) begin
        if (sw_rst_n) begin
            if (rx_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rx_valid_unexpected", {31'd0, rx_valid_o}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rx_data", {24'd0, rx_data_o}, {24'd0, mon_exp});
                end
            end
            if (frame_err_o) begin
                if (exp_err == 0) chk("frame_err_unexpected", {31'd0, frame_err_o}, 32'd0);
                else exp_err--;
            end
        end
    end

    task automatic line(input logic v, input int cycles);
        uart_rx = v;
        repeat (cycles) @(negedge clk_50m);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        if (good) exp_q.push_back(b);
        else exp_err++;
        line(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) line(b[i], BIT_T);
        if (good) line(1'b1, BIT_T);
        else line(1'b0, 2 * BIT_T);
        line(1'b1, 2 * BIT_T);
        if (good) model_byte(b);
    endtask

    // Follow DIGITS consecutive scan steps and compare each against the model
    task automatic check_display(input string tag);
        logic [DIGITS-1:0] prev;
        logic [DIGITS-1:0] m;
        int n, idx, last;
        prev = sels_o;
        last = -1;
        for (int k = 0; k < DIGITS; k++) begin
            n = 0;
            while (sels_o === prev && n < SCAN_DIV + 4) begin
                @(posedge clk_50m);
                #1;
                n++;
            end
            if (sels_o === prev) begin
                chk({tag, "_scan_timeout"}, {{(32-DIGITS){1'b0}}, sels_o}, {{(32-DIGITS){1'b0}}, ~prev});
                return;
            end
            prev = sels_o;
            idx = -1;
            for (int i = 0; i < DIGITS; i++) begin
                m = '0;
                m[i] = 1'b1;
                if (sels_o === ~m) idx = i;
            end
            chk({tag, "_sels_onehot"}, {31'd0, idx >= 0}, 32'd1);
            if (idx >= 0) chk({tag, "_leds"}, {24'd0, leds_o}, {24'd0, seg_tab[model_dig[idx]]});
            if (k > 0) begin
                chk({tag, "_scan_order"}, idx, (last + 1) % DIGITS);
                chk({tag, "_scan_period"}, n, SCAN_DIV);
            end
            last = idx;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_data"}, {24'd0, rx_data_o}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid_o}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err_o}, 32'd0);
        chk({tag, "_leds"}, {24'd0, leds_o}, 32'hFF);
        chk({tag, "_sels"}, {{(32-DIGITS){1'b0}}, sels_o}, {{(32-DIGITS){1'b0}}, {DIGITS{1'b1}}});
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [7:0] b;
        string hexch;
        hexch = "0123456789ABCDEFabcdef";
        model_clear();

        sw_rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        check_reset_values("reset");
        sw_rst_n = 1'b1;
        n = 0;
        while (sels_o === {DIGITS{1'b1}} && n < SCAN_DIV + 4) begin
            @(posedge clk_50m);
            #1;
            n++;
        end
        chk("first_wrap_cycles", n, SCAN_DIV);
        chk("first_wrap_sels", {{(32-DIGITS){1'b0}}, sels_o}, 32'hE);
        chk("first_wrap_leds", {24'd0, leds_o}, 32'hC0);

        send_frame(8'h35, 1'b1);
        check_display("digit5");

        send_frame("1", 1'b1);
        send_frame("2", 1'b1);
        send_frame("3", 1'b1);
        send_frame("4", 1'b1);
        check_display("seq1234");
        send_frame(8'h0C, 1'b1);
        check_display("formfeed");

        send_frame(8'h41, 1'b0);
        check_display("after_ferr");
        send_frame(8'h46, 1'b1);
        check_display("after_ferr_good");

        line(1'b0, 4);
        line(1'b1, 4 * BIT_T);
        send_frame(8'h37, 1'b1);
        check_display("after_glitch");

        line(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) line(i[0], BIT_T);
        line(1'b0, BIT_T / 2);
        sw_rst_n = 1'b0;
        uart_rx  = 1'b1;
        repeat (2) @(negedge clk_50m);
        model_clear();
        check_reset_values("midframe_reset");
        sw_rst_n = 1'b1;
        line(1'b1, 3 * BIT_T);
        send_frame(8'h39, 1'b1);
        check_display("after_midreset");

        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) b = hexch[$urandom_range(0, 21)];
            else if (r == 6) b = 8'h0C;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) != 0));
            line(1'b1, $urandom_range(0, 2 * BIT_T));
            if (t % 3 == 2) check_display("random");
        end
        check_display("random_final");

        repeat (4 * BIT_T) @(negedge clk_50m);
        chk("pending_bytes", exp_q.size(), 0);
        chk("pending_frame_errs", exp_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
